// File: rtl/tpm_locality_arbiter.sv
// TPM locality arbiter: tracks TPM_ACCESS state for each locality, arbitrates
// ownership of the register file and answers TPM_ACCESS reads.
module tpm_locality_arbiter #(
    parameter int          NUM_LOC    = 5,
    parameter logic [11:0] ACCESS_OFF = 12'h000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [15:0]        addr_i,
    input  logic [7:0]         data_i,
    input  logic               data_wr_i,
    input  logic               rd_req_i,
    output logic [7:0]         rd_data_o,
    output logic               rd_valid_o,
    output logic               active_valid_o,
    output logic [2:0]         active_loc_o,
    output logic [NUM_LOC-1:0] pending_o,
    output logic [NUM_LOC-1:0] seized_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_RELEASE
    } state_t;

    localparam logic [3:0] LOC_LIMIT = 4'(NUM_LOC);

    state_t             state_q, state_d;
    logic [2:0]         active_loc_q, active_loc_d;
    logic [NUM_LOC-1:0] pending_q, pending_d;
    logic [NUM_LOC-1:0] seized_q, seized_d;
    logic               rd_valid_q, rd_valid_d;
    logic [7:0]         rd_data_q, rd_data_d;

    logic               loc_in_range;
    logic               wr_hit;
    logic               rd_hit;
    logic [2:0]         loc_sel;
    logic               is_owner;
    logic [2:0]         grant_loc;
    logic [NUM_LOC-1:0] other_mask;

    assign loc_in_range = (addr_i[15:12] < LOC_LIMIT);
    assign wr_hit       = data_wr_i && (addr_i[11:0] == ACCESS_OFF) && loc_in_range;
    assign rd_hit       = rd_req_i && (addr_i[11:0] == ACCESS_OFF) && loc_in_range;
    assign loc_sel      = addr_i[14:12];
    assign is_owner     = (state_q == S_ACTIVE) && (active_loc_q == loc_sel);

    // Highest-numbered pending locality wins; the last match in the loop is kept.
    always_comb begin
        grant_loc = 3'd0;
        for (int i = 0; i < NUM_LOC; i++) begin
            if (pending_q[i]) begin
                grant_loc = 3'(i);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_LOC; gi++) begin : g_mask
            assign other_mask[gi] = (loc_sel != 3'(gi));
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        active_loc_d = active_loc_q;
        pending_d    = pending_q;
        seized_d     = seized_q;
        rd_valid_d   = rd_req_i;
        rd_data_d    = 8'h00;

        if (wr_hit) begin
            if (data_i[5]) begin
                if (is_owner) begin
                    state_d      = S_RELEASE;
                    active_loc_d = 3'd0;
                end else begin
                    pending_d[loc_sel] = 1'b0;
                end
            end else if (data_i[3] && (state_q == S_ACTIVE)) begin
                if (loc_sel > active_loc_q) begin
                    active_loc_d           = loc_sel;
                    seized_d[active_loc_q] = 1'b1;
                    pending_d[loc_sel]     = 1'b0;
                end
            end else if (data_i[3] || data_i[1]) begin
                // Seize with no owner degrades to a plain request.
                if (!is_owner) begin
                    pending_d[loc_sel] = 1'b1;
                end
            end
            if (data_i[4]) begin
                seized_d[loc_sel] = 1'b0;
            end
        end

        if ((state_q == S_IDLE) || (state_q == S_RELEASE)) begin
            if (|pending_q) begin
                state_d              = S_ACTIVE;
                active_loc_d         = grant_loc;
                pending_d[grant_loc] = 1'b0;
            end else begin
                state_d = S_IDLE;
            end
        end

        // Reads reflect state before any write sampled on the same edge.
        if (rd_hit) begin
            rd_data_d = {1'b1, 1'b0, is_owner, seized_q[loc_sel], 1'b0,
                         |(pending_q & other_mask), 1'b0, 1'b1};
        end else if (rd_req_i) begin
            rd_data_d = 8'hFF;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            active_loc_q <= 3'd0;
            pending_q    <= '0;
            seized_q     <= '0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            active_loc_q <= active_loc_d;
            pending_q    <= pending_d;
            seized_q     <= seized_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign active_valid_o = (state_q == S_ACTIVE);
    assign active_loc_o   = active_loc_q;
    assign pending_o      = pending_q;
    assign seized_o       = seized_q;
    assign rd_valid_o     = rd_valid_q;
    assign rd_data_o      = rd_data_q;

endmodule

// File: tb/tb_tpm_locality_arbiter.sv
// Directed bench for tpm_locality_arbiter: ownership handover, seize, cancel,
// TPM_ACCESS read data and reset during a pending grant.
module tb_tpm_locality_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] addr_i;
    logic [7:0]  data_i;
    logic        data_wr_i;
    logic        rd_req_i;
    logic [7:0]  rd_data_o;
    logic        rd_valid_o;
    logic        active_valid_o;
    logic [2:0]  active_loc_o;
    logic [4:0]  pending_o;
    logic [4:0]  seized_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    tpm_locality_arbiter #(
        .NUM_LOC   (5),
        .ACCESS_OFF(12'h000)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .addr_i        (addr_i),
        .data_i        (data_i),
        .data_wr_i     (data_wr_i),
        .rd_req_i      (rd_req_i),
        .rd_data_o     (rd_data_o),
        .rd_valid_o    (rd_valid_o),
        .active_valid_o(active_valid_o),
        .active_loc_o  (active_loc_o),
        .pending_o     (pending_o),
        .seized_o      (seized_o)
    );

    task automatic chk(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
        $display("check %-16s observed=%h expected=%h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk_i);
        addr_i    = a;
        data_i    = d;
        data_wr_i = 1'b1;
        @(posedge clk_i);
        #1;
        data_wr_i = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a);
        @(negedge clk_i);
        addr_i   = a;
        rd_req_i = 1'b1;
        @(posedge clk_i);
        #1;
        rd_req_i = 1'b0;
    endtask

    initial begin
        rst_i     = 1'b1;
        addr_i    = 16'h0000;
        data_i    = 8'h00;
        data_wr_i = 1'b0;
        rd_req_i  = 1'b0;
        tick();
        tick();
        chk("rst_valid",   active_valid_o, 0);
        chk("rst_loc",     active_loc_o, 0);
        chk("rst_pending", pending_o, 0);
        chk("rst_seized",  seized_o, 0);
        chk("rst_rdvalid", rd_valid_o, 0);
        chk("rst_rddata",  rd_data_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Request from idle, grant one cycle later
        wr(16'h0000, 8'h02);
        chk("req0_pending", pending_o, 8'h01);
        chk("req0_novalid", active_valid_o, 0);
        tick();
        chk("grant0_valid",   active_valid_o, 1);
        chk("grant0_loc",     active_loc_o, 0);
        chk("grant0_pending", pending_o, 0);

        // Two requests, relinquish, one-cycle gap, highest wins
        wr(16'h2000, 8'h02);
        chk("req2_pending", pending_o, 8'h04);
        wr(16'h4000, 8'h02);
        chk("req4_pending", pending_o, 8'h14);
        wr(16'h0000, 8'h20);
        chk("rel0_gap", active_valid_o, 0);
        tick();
        chk("grant4_valid",   active_valid_o, 1);
        chk("grant4_loc",     active_loc_o, 4);
        chk("grant4_pending", pending_o, 8'h04);

        // Hand down to loc2, then to idle, then loc1
        wr(16'h4000, 8'h20);
        tick();
        chk("grant2_loc", active_loc_o, 2);
        wr(16'h2000, 8'h20);
        tick();
        chk("idle_valid", active_valid_o, 0);
        wr(16'h1000, 8'h02);
        tick();
        chk("grant1_loc", active_loc_o, 1);

        // Seize by a higher locality
        wr(16'h3000, 8'h08);
        chk("seize_loc",    active_loc_o, 3);
        chk("seize_seized", seized_o, 8'h02);
        chk("seize_valid",  active_valid_o, 1);
        rd(16'h1000);
        chk("rd1_valid", rd_valid_o, 1);
        chk("rd1_data",  rd_data_o, 8'h91);
        tick();
        chk("rd1_drop", rd_valid_o, 0);
        wr(16'h1000, 8'h10);
        chk("clr_seized", seized_o, 0);

        // Lower seize ignored, request then cancel
        wr(16'h2000, 8'h08);
        chk("lowseize_loc",     active_loc_o, 3);
        chk("lowseize_pending", pending_o, 0);
        chk("lowseize_seized",  seized_o, 0);
        wr(16'h2000, 8'h02);
        chk("req2b_pending", pending_o, 8'h04);
        wr(16'h2000, 8'h20);
        chk("cancel2_pending", pending_o, 0);
        chk("cancel2_loc",     active_loc_o, 3);

        // Loc0 active with loc2 pending, read data
        wr(16'h3000, 8'h20);
        tick();
        wr(16'h0000, 8'h02);
        tick();
        chk("grant0b_loc", active_loc_o, 0);
        wr(16'h2000, 8'h02);
        rd(16'h0000);
        chk("rd0_data", rd_data_o, 8'hA5);
        rd(16'h2000);
        chk("rd2_data", rd_data_o, 8'h81);
        rd(16'h0004);
        chk("rd_off_data",  rd_data_o, 8'hFF);
        chk("rd_off_valid", rd_valid_o, 1);
        rd(16'h5000);
        chk("rd_oor_data", rd_data_o, 8'hFF);

        // Read and relinquish in the same cycle returns pre-write state
        @(negedge clk_i);
        addr_i    = 16'h0000;
        data_i    = 8'h20;
        data_wr_i = 1'b1;
        rd_req_i  = 1'b1;
        tick();
        data_wr_i = 1'b0;
        rd_req_i  = 1'b0;
        chk("rdwr_data",  rd_data_o, 8'hA5);
        chk("rdwr_valid", active_valid_o, 0);
        tick();
        chk("grant2b_loc",     active_loc_o, 2);
        chk("grant2b_pending", pending_o, 0);

        // Reset right after a request from idle, with a read in flight
        wr(16'h2000, 8'h20);
        tick();
        wr(16'h1000, 8'h02);
        chk("prereset_pending", pending_o, 8'h02);
        @(negedge clk_i);
        rst_i    = 1'b1;
        rd_req_i = 1'b1;
        addr_i   = 16'h1000;
        tick();
        rst_i    = 1'b0;
        rd_req_i = 1'b0;
        chk("midrst_valid",   active_valid_o, 0);
        chk("midrst_pending", pending_o, 0);
        chk("midrst_rdvalid", rd_valid_o, 0);
        tick();
        tick();
        chk("postrst_valid", active_valid_o, 0);
        chk("postrst_loc",   active_loc_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
